iterative_divider: RTL and testbench



---
 rtl/div_pkg.sv | 23 ++
 rtl/add_and_subtract.sv | 20 ++
 rtl/iterative_divider.sv | 179 +++++++++++++++++
 tb/tb_iterative_divider.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide/remainder unit.
package div_pkg;

  // funct3[1:0] encodings; bit 0 set = unsigned, bit 1 set = remainder
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Default datapath width and the matching iteration counter width
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/add_and_subtract.sv
// Shared adder/subtractor; cout is the carry out, i.e. "no borrow" when subtracting.
module add_and_subtract #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;

  // Two's-complement subtract as a + ~b + 1
  always_comb begin
    b_eff       = subtract ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU sharing one adder across all steps.
module iterative_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int AW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [AW-1:0]    add_a, add_b, add_sum;
  logic             add_sub, add_cout;
  logic             add_msb_unused;

  logic             acc_signed, acc_div0, acc_ovf;
  logic [WIDTH-1:0] fix_sel;
  logic             fix_neg;

  add_and_subtract #(.WIDTH(AW)) u_addsub (
    .a        (add_a),
    .b        (add_b),
    .subtract (add_sub),
    .sum      (add_sum),
    .cout     (add_cout)
  );

  // The top sum bit is never needed: magnitudes and trial remainders fit in WIDTH bits
  assign add_msb_unused = add_sum[AW-1];

  // Adder operand mux, time-multiplexed by state
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state_q)
      ABS_A: begin
        add_sub = 1'b1;
        add_b   = {1'b0, a_q};
      end
      ABS_B: begin
        add_sub = 1'b1;
        add_b   = {1'b0, b_q};
      end
      ITER: begin
        add_sub = 1'b1;
        add_a   = {r_q, a_q[WIDTH-1]};
        add_b   = {1'b0, b_q};
      end
      FIX: begin
        add_sub = 1'b1;
        add_b   = {1'b0, fix_sel};
      end
      default: ;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    q_d        = q_q;
    r_d        = r_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    acc_signed = ~op[0];
    acc_div0   = (divisor == '0);
    acc_ovf    = acc_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    fix_sel    = op_q[1] ? r_q : q_q;
    fix_neg    = op_q[1] ? neg_r_q : neg_q_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d    = op;
          a_d     = dividend;
          b_d     = divisor;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = '0;
          neg_q_d = acc_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d = acc_signed & dividend[WIDTH-1];
          if (acc_div0) begin
            state_d  = DONE;
            result_d = op[1] ? dividend : '1;
          end else if (acc_ovf) begin
            state_d  = DONE;
            result_d = op[1] ? '0 : dividend;
          end else begin
            state_d = ABS_A;
          end
        end
      end
      ABS_A: begin
        if (!op_q[0] && a_q[WIDTH-1]) a_d = add_sum[WIDTH-1:0];
        state_d = ABS_B;
      end
      ABS_B: begin
        if (!op_q[0] && b_q[WIDTH-1]) b_d = add_sum[WIDTH-1:0];
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        if (add_cout) begin
          r_d = add_sum[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = {r_q[WIDTH-2:0], a_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        a_d   = {a_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_neg ? add_sum[WIDTH-1:0] : fix_sel;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      r_q      <= r_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ABS_A) || (state_q == ABS_B) ||
                  (state_q == ITER)  || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider (WIDTH = 32).
module tb_iterative_divider;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op_i;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  iterative_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op_i),
    .dividend (dvd),
    .divisor  (dvs),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op; lat = rising edges after the accepting edge until done is seen
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit saw_busy);
    @(negedge clk);
    start = 1'b1; op_i = o; dvd = a; dvs = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; saw_busy = 1'b0;
    while (!done && lat < 200) begin
      if (busy) saw_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) saw_busy = 1'b1;
    res = result;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; op_i = 2'b00; dvd = '0; dvs = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_signed;
    logic [31:0] r; int lat; bit sb;
    run_op(OP_DIV, 32'd100, 32'd7, r, lat, sb);
    checks++; if (r !== 32'd14) begin failures++; $display("FAIL div_100_7 got=%h exp=%h", r, 32'd14); end
    checks++; if (lat !== 35) begin failures++; $display("FAIL div_latency got=%0d exp=35", lat); end
    checks++; if (sb !== 1'b1) begin failures++; $display("FAIL div_busy got=%b exp=1", sb); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL result_hold got=%h exp=%h", result, 32'd14); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", done); end
    run_op(OP_REM, 32'd100, 32'd7, r, lat, sb);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL rem_100_7 got=%h exp=%h", r, 32'd2); end
    run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, r, lat, sb);
    checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL rem_m100_7 got=%h exp=fffffffe", r); end
    checks++; if (lat !== 35) begin failures++; $display("FAIL rem_neg_latency got=%0d exp=35", lat); end
    run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, r, lat, sb);
    checks++; if (r !== 32'hFFFF_FFF2) begin failures++; $display("FAIL div_100_m7 got=%h exp=fffffff2", r); end
  endtask

  task automatic test_unsigned;
    logic [31:0] r; int lat; bit sb;
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2, r, lat, sb);
    checks++; if (r !== 32'h7FFF_FFFF) begin failures++; $display("FAIL divu_max_2 got=%h exp=7fffffff", r); end
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'd2, r, lat, sb);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL remu_max_2 got=%h exp=00000001", r); end
  endtask

  task automatic test_special;
    logic [1:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp [4];
    logic [31:0] r; int lat; bit sb;
    ops[0] = OP_DIV; as[0] = 32'd5;         bs[0] = 32'd0;         exp[0] = 32'hFFFF_FFFF;
    ops[1] = OP_REM; as[1] = 32'd5;         bs[1] = 32'd0;         exp[1] = 32'd5;
    ops[2] = OP_DIV; as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF; exp[2] = 32'h8000_0000;
    ops[3] = OP_REM; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; exp[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, sb);
      checks++; if (r !== exp[i]) begin failures++; $display("FAIL special_%0d_result got=%h exp=%h", i, r, exp[i]); end
      checks++; if (lat !== 0) begin failures++; $display("FAIL special_%0d_latency got=%0d exp=0", i, lat); end
      checks++; if (sb !== 1'b0) begin failures++; $display("FAIL special_%0d_busy got=%b exp=0", i, sb); end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    start = 1'b1; op_i = OP_DIV; dvd = 32'd100; dvs = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      start = (lat == 10);
      if (lat == 10) begin op_i = OP_REM; dvd = 32'd1000; dvs = 32'd3; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL ignore_start_result got=%h exp=%h", result, 32'd14); end
    checks++; if (lat !== 35) begin failures++; $display("FAIL ignore_start_latency got=%0d exp=35", lat); end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    @(negedge clk);
    start = 1'b1; op_i = OP_DIVU; dvd = 32'd1000; dvs = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=00000000", result); end
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", seen_done); end
  endtask

  task automatic test_back_to_back;
    int lat, gap;
    @(negedge clk);
    start = 1'b1; op_i = OP_DIVU; dvd = 32'd9; dvs = 32'd3;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (result !== 32'd3) begin failures++; $display("FAIL b2b_first got=%h exp=00000003", result); end
    op_i = OP_REMU; dvd = 32'd10; dvs = 32'd4;
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) start = 1'b0;
    end while (!done && gap < 200);
    start = 1'b0;
    checks++; if (result !== 32'd2) begin failures++; $display("FAIL b2b_second got=%h exp=00000002", result); end
    checks++; if (gap !== 36) begin failures++; $display("FAIL b2b_gap got=%0d exp=36", gap); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_special();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
